// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types, constants and helpers for the parametrised APB bridge
package apb_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam logic [31:0] APB_DECERR_DATA_DEFAULT = 32'hDEC0_DEAD;

   // One-hot select for slot idx; all-zero when idx is not a populated slot.
   function automatic logic [31:0] sel_onehot(input logic [4:0] idx, input int unsigned n);
      logic [31:0] v;
      v = '0;
      if (32'(idx) < n) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/apb_bridge_param_if.sv
// rtl/apb_bridge_param_if.sv - host request and APB slot bundle for apb_bridge_param
interface apb_bridge_param_if #(
   parameter int NUM_SLAVES = 16,
   parameter int PADDR_W    = 24
);
   logic                        host_valid;
   logic                        host_ready;
   logic [31:0]                 host_addr;
   logic [31:0]                 host_wdata;
   logic [3:0]                  host_wstrb;
   logic [31:0]                 host_rdata;
   logic                        host_slverr;
   logic [PADDR_W-1:0]          apb_paddr;
   logic                        apb_pwrite;
   logic [31:0]                 apb_pwdata;
   logic [3:0]                  apb_pstrb;
   logic                        apb_penable;
   logic [NUM_SLAVES-1:0]       apb_psel;
   logic [NUM_SLAVES-1:0][31:0] apb_prdata;
   logic [NUM_SLAVES-1:0]       apb_pready;
   logic [NUM_SLAVES-1:0]       apb_pslverr;

   modport master (
      input  host_valid, host_addr, host_wdata, host_wstrb,
      input  apb_prdata, apb_pready, apb_pslverr,
      output host_ready, host_rdata, host_slverr,
      output apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_penable, apb_psel
   );

   modport slave (
      output host_valid, host_addr, host_wdata, host_wstrb,
      output apb_prdata, apb_pready, apb_pslverr,
      input  host_ready, host_rdata, host_slverr,
      input  apb_paddr, apb_pwrite, apb_pwdata, apb_pstrb, apb_penable, apb_psel
   );
endinterface

// File: rtl/apb_watchdog.sv
// rtl/apb_watchdog.sv - load/enable counter flagging the last permitted ACCESS cycle
module apb_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc
);
   localparam int unsigned CW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam int unsigned TC_VAL = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)       r_cnt <= '0;
      else if (i_load) r_cnt <= '0;
      else if (i_en)   r_cnt <= r_cnt + CW'(1);
   end

   // A zero timeout never expires; the counter may wrap harmlessly.
   assign o_tc = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TC_VAL));
endmodule

// File: rtl/apb_bridge_param.sv
// rtl/apb_bridge_param.sv - host valid/ready to APB3 bridge with decode errors and watchdog
module apb_bridge_param
   import apb_bridge_pkg::*;
#(
   parameter int unsigned NUM_SLAVES     = 16,
   parameter int unsigned PADDR_W        = 24,
   parameter int unsigned SEL_W          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] DECERR_DATA    = APB_DECERR_DATA_DEFAULT
)(
   input  logic               sys_clk,
   input  logic               rst,
   apb_bridge_param_if.master bus
);
   apb_state_e            r_state, w_next_state;
   logic [SEL_W-1:0]      w_slot, r_slot;
   logic                  w_decerr;
   logic [PADDR_W-1:0]    r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic [31:0]           r_rdata;
   logic                  r_slverr;
   logic                  w_pready, w_pslverr, w_tc;
   logic [31:0]           w_prdata;
   logic [31:0]           w_onehot;
   logic [NUM_SLAVES-1:0] w_psel;
   logic                  w_penable, w_host_ready;

   assign w_slot   = bus.host_addr[PADDR_W+SEL_W-1:PADDR_W];
   assign w_decerr = (32'(w_slot) >= NUM_SLAVES);

   generate
      if (PADDR_W + SEL_W < 32) begin : g_unused
         logic w_unused_hi;
         assign w_unused_hi = ^bus.host_addr[31:PADDR_W+SEL_W];
      end
   endgenerate

   // Only the latched slot's response lines are ever looked at.
   always_comb begin
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      w_prdata  = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (r_slot == SEL_W'(i)) begin
            w_pready  = bus.apb_pready[i];
            w_pslverr = bus.apb_pslverr[i];
            w_prdata  = bus.apb_prdata[i];
         end
      end
   end

   apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
      .i_clk  (sys_clk),
      .i_rst  (rst),
      .i_load (r_state != ST_ACCESS),
      .i_en   (r_state == ST_ACCESS),
      .o_tc   (w_tc)
   );

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (bus.host_valid) w_next_state = w_decerr ? ST_RESP : ST_SETUP;
         ST_SETUP:  w_next_state = ST_ACCESS;
         ST_ACCESS: if (w_pready || w_tc) w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_psel       = '0;
      w_penable    = 1'b0;
      w_host_ready = 1'b0;
      w_onehot     = sel_onehot(5'(r_slot), NUM_SLAVES);
      case (r_state)
         ST_SETUP:  w_psel = w_onehot[NUM_SLAVES-1:0];
         ST_ACCESS: begin
            w_psel    = w_onehot[NUM_SLAVES-1:0];
            w_penable = 1'b1;
         end
         ST_RESP:   w_host_ready = 1'b1;
         default:   ;
      endcase
   end

   // Request fields are captured only in IDLE, so host changes mid-transfer are ignored.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_slot   <= '0;
         r_rdata  <= '0;
         r_slverr <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.host_valid) begin
                  if (w_decerr) begin
                     r_rdata  <= DECERR_DATA;
                     r_slverr <= 1'b1;
                  end else begin
                     r_addr  <= bus.host_addr[PADDR_W-1:0];
                     r_wdata <= bus.host_wdata;
                     r_wstrb <= bus.host_wstrb;
                     r_slot  <= w_slot;
                  end
               end
            end
            ST_ACCESS: begin
               // A ready in the expiry cycle wins over the watchdog.
               if (w_pready) begin
                  r_rdata  <= (r_wstrb != 4'd0) ? 32'd0 : w_prdata;
                  r_slverr <= w_pslverr;
               end else if (w_tc) begin
                  r_rdata  <= '0;
                  r_slverr <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.host_ready  = w_host_ready;
   assign bus.host_rdata  = r_rdata;
   assign bus.host_slverr = r_slverr;
   assign bus.apb_paddr   = r_addr;
   assign bus.apb_pwrite  = (r_wstrb != 4'd0);
   assign bus.apb_pwdata  = r_wdata;
   assign bus.apb_pstrb   = r_wstrb;
   assign bus.apb_penable = w_penable;
   assign bus.apb_psel    = w_psel;
endmodule

// File: tb/tb_apb_bridge_param.sv
// tb/tb_apb_bridge_param.sv - scoreboard bench for apb_bridge_param (16-slot and 12-slot/T=8 builds)
module tb_apb_bridge_param;

   typedef struct {
      logic [31:0] rdata;
      logic        slverr;
      int          start;
      int          lat;
   } exp_t;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   always #5 sys_clk = ~sys_clk;

   apb_bridge_param_if #(.NUM_SLAVES(16), .PADDR_W(24)) ifa ();
   apb_bridge_param_if #(.NUM_SLAVES(12), .PADDR_W(24)) ifb ();

   apb_bridge_param dut_a (.sys_clk(sys_clk), .rst(rst), .bus(ifa.master));
   apb_bridge_param #(.NUM_SLAVES(12), .TIMEOUT_CYCLES(8)) dut_b (
      .sys_clk(sys_clk), .rst(rst), .bus(ifb.master));

   exp_t        q_a[$], q_b[$];
   int          n_cmp = 0, n_err = 0, cyc = 0;
   int          waits_a[16], waits_b[16];
   bit          err_a[16], hung_b[16];
   int          wa, wb;
   logic [23:0] cap_paddr;
   logic [31:0] cap_pwdata;
   logic [3:0]  cap_pstrb;
   logic        cap_pwrite;
   logic [15:0] po;
   int          pc;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(posedge sys_clk or posedge rst) begin
      if (rst) wa <= 0;
      else if (ifa.apb_penable && !(|ifa.apb_pready)) wa <= wa + 1;
      else wa <= 0;
   end

   always @(posedge sys_clk or posedge rst) begin
      if (rst) wb <= 0;
      else if (ifb.apb_penable && !(|ifb.apb_pready)) wb <= wb + 1;
      else wb <= 0;
   end

   // Slot s returns {4'hA, s, paddr}; ready after waits[s] ACCESS cycles.
   always_comb begin
      ifa.apb_pready  = '0;
      ifa.apb_pslverr = '0;
      ifa.apb_prdata  = '0;
      for (int s = 0; s < 16; s++) begin
         ifa.apb_prdata[s] = {4'hA, 4'(s), ifa.apb_paddr};
         if (ifa.apb_psel[s] && ifa.apb_penable && wa >= waits_a[s]) begin
            ifa.apb_pready[s]  = 1'b1;
            ifa.apb_pslverr[s] = err_a[s];
         end
      end
   end

   always_comb begin
      ifb.apb_pready  = '0;
      ifb.apb_pslverr = '0;
      ifb.apb_prdata  = '0;
      for (int s = 0; s < 12; s++) begin
         ifb.apb_prdata[s] = {4'hA, 4'(s), ifb.apb_paddr};
         if (ifb.apb_psel[s] && ifb.apb_penable && !hung_b[s] && wb >= waits_b[s])
            ifb.apb_pready[s] = 1'b1;
      end
   end

   always @(negedge sys_clk) begin
      exp_t e;
      if (ifa.host_ready) begin
         if (q_a.size() == 0) check_eq("a_unexpected_ready", {31'b0, ifa.host_ready}, 32'd0);
         else begin
            e = q_a.pop_front();
            check_eq("a_rdata",   ifa.host_rdata, e.rdata);
            check_eq("a_slverr",  {31'b0, ifa.host_slverr}, {31'b0, e.slverr});
            check_eq("a_latency", cyc - e.start, e.lat);
         end
      end
      if (ifb.host_ready) begin
         if (q_b.size() == 0) check_eq("b_unexpected_ready", {31'b0, ifb.host_ready}, 32'd0);
         else begin
            e = q_b.pop_front();
            check_eq("b_rdata",   ifb.host_rdata, e.rdata);
            check_eq("b_slverr",  {31'b0, ifb.host_slverr}, {31'b0, e.slverr});
            check_eq("b_latency", cyc - e.start, e.lat);
         end
      end
   end

   task automatic xfer(input bit use_b, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] er, input logic ee,
                       input int lat, output logic [15:0] psel_or, output int pen_cnt);
      exp_t e;
      bit   got;
      @(negedge sys_clk);
      e.rdata = er; e.slverr = ee; e.start = cyc; e.lat = lat;
      if (use_b) begin
         q_b.push_back(e);
         ifb.host_valid = 1'b1; ifb.host_addr = addr; ifb.host_wdata = wdata; ifb.host_wstrb = wstrb;
      end else begin
         q_a.push_back(e);
         ifa.host_valid = 1'b1; ifa.host_addr = addr; ifa.host_wdata = wdata; ifa.host_wstrb = wstrb;
      end
      psel_or = '0; pen_cnt = 0; got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge sys_clk);
         if (use_b) begin
            psel_or |= 16'(ifb.apb_psel);
            pen_cnt += int'(ifb.apb_penable);
            got = ifb.host_ready;
         end else begin
            psel_or |= ifa.apb_psel;
            pen_cnt += int'(ifa.apb_penable);
            if (ifa.apb_penable) begin
               cap_paddr = ifa.apb_paddr; cap_pwdata = ifa.apb_pwdata;
               cap_pstrb = ifa.apb_pstrb; cap_pwrite = ifa.apb_pwrite;
            end
            got = ifa.host_ready;
         end
         // Disturb the host bus after launch; latched fields must not follow.
         if (!got && i == 0) begin
            if (use_b) begin ifb.host_addr = $urandom; ifb.host_wdata = $urandom; end
            else       begin ifa.host_addr = $urandom; ifa.host_wdata = $urandom; end
         end
      end
      check_eq("ready_seen", {31'b0, got}, 32'd1);
      if (use_b) ifb.host_valid = 1'b0;
      else       ifa.host_valid = 1'b0;
   endtask

   initial begin
      ifa.host_valid = 0; ifa.host_addr = 0; ifa.host_wdata = 0; ifa.host_wstrb = 0;
      ifb.host_valid = 0; ifb.host_addr = 0; ifb.host_wdata = 0; ifb.host_wstrb = 0;
      for (int s = 0; s < 16; s++) begin
         waits_a[s] = 0; waits_b[s] = 0; err_a[s] = 0; hung_b[s] = 0;
      end
      repeat (3) @(negedge sys_clk);
      check_eq("rst_ready",   {31'b0, ifa.host_ready}, 32'd0);
      check_eq("rst_psel",    {16'b0, ifa.apb_psel}, 32'd0);
      check_eq("rst_penable", {31'b0, ifa.apb_penable}, 32'd0);
      check_eq("rst_rdata",   ifa.host_rdata, 32'd0);
      check_eq("rst_slverr",  {31'b0, ifa.host_slverr}, 32'd0);
      check_eq("rst_paddr",   {8'b0, ifa.apb_paddr}, 32'd0);
      check_eq("rst_b_psel",  {20'b0, ifb.apb_psel}, 32'd0);
      rst = 1'b0;

      xfer(0, 32'h0012_3456, 32'h0, 4'h0, 32'hA012_3456, 1'b0, 3, po, pc);
      check_eq("t1_psel", {16'b0, po}, 32'h0001);

      xfer(0, 32'h0F87_6543, 32'h9988_7766, 4'hF, 32'h0, 1'b0, 3, po, pc);
      check_eq("t2_psel",   {16'b0, po}, 32'h8000);
      check_eq("t2_paddr",  {8'b0, cap_paddr}, 32'h0087_6543);
      check_eq("t2_pwdata", cap_pwdata, 32'h9988_7766);
      check_eq("t2_pstrb",  {28'b0, cap_pstrb}, 32'hF);
      check_eq("t2_pwrite", {31'b0, cap_pwrite}, 32'd1);

      xfer(1, 32'h0D00_0010, 32'h0, 4'h0, 32'hDEC0_DEAD, 1'b1, 1, po, pc);
      check_eq("t3_psel", {16'b0, po}, 32'h0);
      check_eq("t3_pen",  pc, 32'd0);
      xfer(1, 32'h0C00_0000, 32'h0, 4'h0, 32'hDEC0_DEAD, 1'b1, 1, po, pc);
      check_eq("t3_slot12_psel", {16'b0, po}, 32'h0);
      xfer(1, 32'h0B00_0008, 32'h0, 4'h0, 32'hAB00_0008, 1'b0, 3, po, pc);
      check_eq("t3_slot11_psel", {16'b0, po}, 32'h0800);

      hung_b[2] = 1;
      xfer(1, 32'h0200_0044, 32'h0, 4'h0, 32'h0, 1'b1, 10, po, pc);
      check_eq("t4_pen_cycles", pc, 32'd8);
      check_eq("t4_psel", {16'b0, po}, 32'h0004);
      hung_b[2] = 0; waits_b[2] = 7;
      xfer(1, 32'h0200_0044, 32'h0, 4'h0, 32'hA200_0044, 1'b0, 10, po, pc);
      check_eq("t4_edge_pen_cycles", pc, 32'd8);

      waits_a[1] = 3; err_a[1] = 1;
      xfer(0, 32'h3100_0010, 32'h0, 4'h0, 32'hA100_0010, 1'b1, 6, po, pc);
      check_eq("t5_psel", {16'b0, po}, 32'h0002);

      waits_a[3] = 10;
      @(negedge sys_clk);
      ifa.host_valid = 1'b1; ifa.host_addr = 32'h0300_0020; ifa.host_wstrb = 4'h0;
      repeat (2) @(negedge sys_clk);
      check_eq("t6_pen_before", {31'b0, ifa.apb_penable}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("t6_psel_rst", {16'b0, ifa.apb_psel}, 32'h0);
      check_eq("t6_pen_rst",  {31'b0, ifa.apb_penable}, 32'd0);
      check_eq("t6_rdata_rst", ifa.host_rdata, 32'h0);
      ifa.host_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
      rst = 1'b0;
      repeat (15) @(negedge sys_clk);
      waits_a[3] = 0;
      xfer(0, 32'h0000_0100, 32'h0, 4'h0, 32'hA000_0100, 1'b0, 3, po, pc);

      repeat (3) @(negedge sys_clk);
      check_eq("sb_a_empty", q_a.size(), 32'd0);
      check_eq("sb_b_empty", q_b.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got simulation time %0t expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/apb_bridge_param.md
# apb_bridge_param

Parametrised host-to-APB bridge: the next generation of `apb_bridge_top`, converting the MCU host memory request (valid/ready) into APB3 transfers on up to 32 peripheral slots. It adds three things:
- a configurable slot count and address split;
- decode-error responses for unpopulated slots;
- a per-transfer watchdog that terminates hung slaves with `host_slverr`.

It sits between the MCU bus and all register-mapped GNSS peripherals.

## Interface
Parameters:
- `NUM_SLAVES`, 16: populated APB slots, 1..32.
- `PADDR_W`, 24: width of `apb_paddr`; host address bits [PADDR_W-1:0] pass through.
- `SEL_W`, 4: slot-select field width, host bits [PADDR_W+SEL_W-1:PADDR_W]; requires 2^SEL_W >= NUM_SLAVES.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before forced error; 0 disables the watchdog.
- `DECERR_DATA`, 32'hDEC0_DEAD: `host_rdata` returned on decode error.

Ports:
- `sys_clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `host_valid`  in  1  request; held until `host_ready`.
- `host_ready`  out  1  one-cycle completion pulse.
- `host_addr`  in  32  byte address; bits above the select field are ignored.
- `host_wdata`  in  32  write data.
- `host_wstrb`  in  4  byte strobes; nonzero = write, zero = read.
- `host_rdata`  out  32  read data, valid while `host_ready`=1.
- `host_slverr`  out  1  error, valid while `host_ready`=1.
- `apb_paddr`  out  PADDR_W  shared address.
- `apb_pwrite`  out  1  shared direction.
- `apb_pwdata`  out  32  shared write data.
- `apb_pstrb`  out  4  shared strobes; 0 on reads.
- `apb_penable`  out  1  shared enable.
- `apb_psel`  out  NUM_SLAVES  one-hot select.
- `apb_prdata`  in  NUM_SLAVES x 32  per-slot read data.
- `apb_pready`  in  NUM_SLAVES  per-slot ready.
- `apb_pslverr`  in  NUM_SLAVES  per-slot error.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `host_valid`=1 with slot < NUM_SLAVES: latch address, wdata, strobes and slot index; go to SETUP.
  - `host_valid`=1 with slot >= NUM_SLAVES: go to RESP with slverr=1 and rdata=DECERR_DATA. No psel is asserted.
- **SETUP**: `apb_psel[slot]`=1, `apb_penable`=0. Always advances to ACCESS.
- **ACCESS**: `apb_psel[slot]`=1, `apb_penable`=1. The watchdog counter increments every cycle.
  - `apb_pready[slot]`=1: capture `apb_prdata[slot]` (reads only; writes return 0) and `apb_pslverr[slot]`; go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without pready: deassert psel/penable, go to RESP with slverr=1, rdata=0.
- **RESP**: `host_ready`=1 for exactly one cycle, then IDLE. Registered rdata/slverr hold until the next RESP.
- Latched request fields are frozen from IDLE until RESP. Host changes to addr/wdata mid-transfer have no effect.
- `host_valid` dropping mid-transfer does not abort the transfer; it completes and `host_ready` still pulses.
- `apb_pwrite` = latched (wstrb != 0). `apb_pstrb` = latched wstrb for writes, 0 for reads.
- The slverr output mux ignores pslverr from non-selected slots.

## Timing
- Reset values: every output is 0, FSM is IDLE, watchdog counter is 0. Reset is asynchronous and fully restarts the block.
- Reset asserted mid-transfer: psel/penable drop immediately; no `host_ready` is generated for the killed request.
- Zero-wait slave: valid sampled at edge N gives SETUP in cycle N+1, ACCESS in N+2, and `host_ready` high in cycle N+3.
- Each pready wait state adds 1 cycle. A decode error gives `host_ready` in cycle N+1.
- Watchdog: with TIMEOUT_CYCLES=T, ACCESS lasts at most T cycles. Pready arriving in the same cycle as expiry takes priority and is a normal completion.
- Back-to-back requests: the cycle after RESP is IDLE, and a still-high `host_valid` there starts the next transfer. Minimum period is 4 cycles.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- `apb_bridge_pkg`: state enum `apb_state_e`, constant `APB_DECERR_DATA_DEFAULT`, and the helper function `sel_onehot(idx, n)`.
- Sub-module `apb_watchdog`: a load/enable counter with a terminal-count output, parametrised by TIMEOUT_CYCLES, with 0 meaning never expire.
- The top level holds the FSM, the request latch and the response muxes.

## Test plan
1. **Slot 0 read.** Zero-wait slave returning {8'hA0, paddr}; read 32'h00123456.
   - Expect rdata 32'hA0123456, slverr 0, `host_ready` 3 cycles after valid is sampled.
2. **Slot 15 write.** Write 32'h0F876543 with data 32'h99887766, wstrb 4'hF.
   - Expect paddr 24'h876543, pwdata 32'h99887766, pstrb 4'hF, pwrite 1, psel exactly 16'h8000.
3. **Decode error.** NUM_SLAVES=12, read 32'h0D000010.
   - Expect no psel bit ever set, rdata 32'hDEC0DEAD, slverr 1, `host_ready` 1 cycle after valid is sampled.
4. **Watchdog.** TIMEOUT_CYCLES=8, slot 2 pready tied 0.
   - Expect penable high for exactly 8 cycles, then slverr 1 and rdata 0. Then repeat with pready arriving on the 8th cycle: expect normal completion.
5. **Wait states and slave error.** Slot 1 inserts 3 wait states and drives pslverr=1 on its pready cycle.
   - Expect `host_ready` at cycle N+6 and slverr 1. Check that bits [31:28]=4'h3 in the address do not change the selected slot.
6. **Reset mid-transfer.** Assert reset during ACCESS.
   - Expect psel/penable 0 in the same cycle and no `host_ready`. A fresh read after reset release completes normally.
